fp16_normalize_round: RTL and testbench



---
 rtl/fp16_normalize_round.sv | 162 ++++++++++++++++
 tb/tb_fp16_normalize_round.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fp16_normalize_round.sv
// Normalize-and-round stage of the half-precision adder: shifts the raw mantissa
// sum one bit per cycle, then computes round-to-nearest-even for the packing stage.
module fp16_normalize_round #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               sign_in,
    input  logic [EXP_W-1:0]   exp_in,
    input  logic [MAN_W+3:0]   sum_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sign_out,
    output logic [EXP_W-1:0]   exp_out,
    output logic [MAN_W-1:0]   Rm,
    output logic               arround,
    output logic               carry,
    output logic               overflow
);

    localparam int SUM_W      = MAN_W + 4;
    localparam int MAX_SHIFTS = MAN_W + 1;
    localparam int CNT_W      = $clog2(MAX_SHIFTS + 1);
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_t;

    state_t             state_reg, state_next;
    logic [SUM_W-1:0]   sum_reg, sum_next;
    logic [EXP_W-1:0]   exp_reg, exp_next;
    logic               sign_reg, sign_next;
    logic [CNT_W-1:0]   shift_cnt_reg, shift_cnt_next;

    logic               sign_out_reg, sign_out_next;
    logic [EXP_W-1:0]   exp_out_reg, exp_out_next;
    logic [MAN_W-1:0]   rm_reg, rm_next;
    logic               arround_reg, arround_next;
    logic               carry_reg, carry_next;
    logic               overflow_reg, overflow_next;

    logic [MAN_W-1:0]   frac;
    logic               round_up;

    assign frac     = sum_reg[MAN_W+1:2];
    // Round to nearest, ties to even: guard set and (sticky set or fraction LSB odd)
    assign round_up = sum_reg[1] & (sum_reg[0] | sum_reg[2]);

    always_comb begin
        state_next     = state_reg;
        sum_next       = sum_reg;
        exp_next       = exp_reg;
        sign_next      = sign_reg;
        shift_cnt_next = shift_cnt_reg;
        sign_out_next  = sign_out_reg;
        exp_out_next   = exp_out_reg;
        rm_next        = rm_reg;
        arround_next   = arround_reg;
        carry_next     = carry_reg;
        overflow_next  = overflow_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    sum_next       = sum_in;
                    exp_next       = exp_in;
                    sign_next      = sign_in;
                    shift_cnt_next = '0;
                    state_next     = ALIGN;
                end
            end
            ALIGN: begin
                if (sum_reg == '0) begin
                    sign_out_next = sign_reg;
                    exp_out_next  = '0;
                    rm_next       = '0;
                    arround_next  = 1'b0;
                    carry_next    = 1'b0;
                    overflow_next = 1'b0;
                    state_next    = DONE;
                end else if (sum_reg[SUM_W-1]) begin
                    // Right shift by one, folding the dropped guard into sticky
                    sum_next   = {1'b0, sum_reg[SUM_W-1:2], sum_reg[1] | sum_reg[0]};
                    exp_next   = (exp_reg == EXP_MAX) ? exp_reg : exp_reg + 1'b1;
                    state_next = ROUND;
                end else if (sum_reg[SUM_W-2] || (exp_reg <= EXP_ONE) ||
                             (shift_cnt_reg == CNT_W'(MAX_SHIFTS))) begin
                    state_next = ROUND;
                end else begin
                    sum_next       = {sum_reg[SUM_W-2:0], 1'b0};
                    exp_next       = exp_reg - 1'b1;
                    shift_cnt_next = shift_cnt_reg + 1'b1;
                end
            end
            ROUND: begin
                sign_out_next = sign_reg;
                if (exp_reg == EXP_MAX) begin
                    exp_out_next  = EXP_MAX;
                    rm_next       = '0;
                    arround_next  = 1'b0;
                    carry_next    = 1'b0;
                    overflow_next = 1'b1;
                end else begin
                    // Hidden bit still clear here means a subnormal result
                    exp_out_next  = sum_reg[SUM_W-2] ? exp_reg : '0;
                    rm_next       = frac;
                    arround_next  = round_up;
                    carry_next    = round_up & (&frac);
                    overflow_next = 1'b0;
                end
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            sum_reg       <= '0;
            exp_reg       <= '0;
            sign_reg      <= 1'b0;
            shift_cnt_reg <= '0;
            sign_out_reg  <= 1'b0;
            exp_out_reg   <= '0;
            rm_reg        <= '0;
            arround_reg   <= 1'b0;
            carry_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sum_reg       <= sum_next;
            exp_reg       <= exp_next;
            sign_reg      <= sign_next;
            shift_cnt_reg <= shift_cnt_next;
            sign_out_reg  <= sign_out_next;
            exp_out_reg   <= exp_out_next;
            rm_reg        <= rm_next;
            arround_reg   <= arround_next;
            carry_reg     <= carry_next;
            overflow_reg  <= overflow_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign sign_out  = sign_out_reg;
    assign exp_out   = exp_out_reg;
    assign Rm        = rm_reg;
    assign arround   = arround_reg;
    assign carry     = carry_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_fp16_normalize_round.sv
// Bench for fp16_normalize_round: directed cases plus random operands checked
// against an arithmetic reference model, with random downstream backpressure.
module tb_fp16_normalize_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [4:0]  exp_in;
    logic [13:0] sum_in;
    logic        out_valid;
    logic        out_ready;
    logic        sign_out;
    logic [4:0]  exp_out;
    logic [9:0]  Rm;
    logic        arround;
    logic        carry;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int op_num = 0;

    fp16_normalize_round #(.EXP_W(5), .MAN_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .sum_in    (sum_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign_out  (sign_out),
        .exp_out   (exp_out),
        .Rm        (Rm),
        .arround   (arround),
        .carry     (carry),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (op %0d)", tag, got, want, op_num);
        end
    endtask

    // Reference: normalize by plain multiply/divide on an integer, then round.
    function automatic void model(input int e_in, input int s_in,
                                  output int xe, output int xrm, output int xarr,
                                  output int xc, output int xov, output int xlat);
        int e, s, k, frac, g, st;
        e = e_in;
        s = s_in;
        xe = 0; xrm = 0; xarr = 0; xc = 0; xov = 0;
        if (s == 0) begin
            xlat = 1;
            return;
        end
        if (s >= 8192) begin
            s = (s / 2) | (s % 2);
            e = e + 1;
            xlat = 2;
        end else begin
            k = 0;
            while (s < 4096 && e > 1 && k < 11) begin
                s = s * 2;
                e = e - 1;
                k++;
            end
            xlat = 2 + k;
        end
        if (e >= 31) begin
            xe = 31;
            xov = 1;
            return;
        end
        frac = (s / 4) % 1024;
        g    = (s / 2) % 2;
        st   = s % 2;
        xarr = (g == 1 && (st == 1 || frac % 2 == 1)) ? 1 : 0;
        xc   = (xarr == 1 && frac == 1023) ? 1 : 0;
        xrm  = frac;
        xe   = (s >= 4096) ? e : 0;
    endfunction

    // Called at #1 after a posedge with the DUT idle.
    task automatic run_op(input logic sg, input int e, input int s, input int hold);
        int xe, xrm, xarr, xc, xov, xlat, n;
        logic [4:0] held_exp;
        logic [9:0] held_rm;
        model(e, s, xe, xrm, xarr, xc, xov, xlat);
        op_num++;
        sign_in  = sg;
        exp_in   = e[4:0];
        sum_in   = s[13:0];
        in_valid = 1'b1;
        check_eq("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = (hold == 0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("latency", n, xlat);
        check_eq("exp_out", exp_out, xe);
        check_eq("Rm", Rm, xrm);
        check_eq("arround", arround, xarr);
        check_eq("carry", carry, xc);
        check_eq("overflow", overflow, xov);
        check_eq("sign_out", sign_out, sg);
        $display("op %0d: sign=%0d exp_in=%0d sum_in=%h -> lat=%0d exp_out=%0d Rm=%h arround=%0d carry=%0d overflow=%0d",
                 op_num, sg, e, s[13:0], n, exp_out, Rm, arround, carry, overflow);
        held_exp = exp_out;
        held_rm  = Rm;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            sum_in   = 14'h2AAA;
            exp_in   = 5'd7;
            @(posedge clk); #1;
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_in_ready", in_ready, 0);
            check_eq("hold_exp", exp_out, held_exp);
            check_eq("hold_rm", Rm, held_rm);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("post_valid", out_valid, 0);
        check_eq("post_in_ready", in_ready, 1);
        check_eq("retain_rm", Rm, held_rm);
    endtask

    initial begin
        int e, s, sh;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sign_in   = 1'b0;
        exp_in    = '0;
        sum_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_exp_out", exp_out, 0);
        check_eq("rst_rm", Rm, 0);
        check_eq("rst_overflow", overflow, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(1'b0, 15, 14'h1000, 0);
        run_op(1'b1, 15, 14'h3001, 0);
        run_op(1'b0, 30, 14'h2000, 0);
        run_op(1'b0, 15, 14'h0040, 0);
        run_op(1'b1, 3,  14'h0100, 0);
        run_op(1'b0, 10, 14'h1FFE, 0);
        run_op(1'b0, 10, 14'h100A, 0);
        run_op(1'b0, 10, 14'h100B, 0);
        run_op(1'b0, 12, 14'h0000, 5);
        run_op(1'b0, 20, 14'h0001, 0);

        // Reset during the third ALIGN cycle of a six-shift operation
        sign_in  = 1'b0;
        exp_in   = 5'd15;
        sum_in   = 14'h0040;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_exp_out", exp_out, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(1'b1, 15, 14'h0040, 0);

        for (int i = 0; i < 200; i++) begin
            e  = $urandom_range(0, 30);
            sh = $urandom_range(0, 13);
            s  = ($urandom & 32'h3FFF) >> sh;
            if ($urandom_range(0, 19) == 0) s = 0;
            run_op(1'($urandom & 1), e, s, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
